// File: rtl/byte_fetch_sequencer_pkg.sv
// byte_fetch_sequencer_pkg: mode, FunSel and state encodings shared by the byte fetch sequencer files
package byte_fetch_sequencer_pkg;
  typedef enum logic [1:0] {
    MODE_WORD = 2'b00,
    MODE_ZEXT = 2'b01,
    MODE_SEXT = 2'b10,
    MODE_HIGH = 2'b11
  } mode_t;
  localparam logic [2:0] FS_DEC    = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOAD   = 3'b010;
  localparam logic [2:0] FS_CLR    = 3'b011;
  localparam logic [2:0] FS_LO_CLR = 3'b100;
  localparam logic [2:0] FS_LO     = 3'b101;
  localparam logic [2:0] FS_HI     = 3'b110;
  localparam logic [2:0] FS_SEXT   = 3'b111;
  typedef enum logic [2:0] {IDLE, REQ_LO, WR_LO, REQ_HI, WR_HI, FIN, ERR} state_t;
endpackage

// File: rtl/byte_fetch_sequencer_if.sv
// byte_fetch_sequencer_if: 8-bit memory read port
//   Mem_Req/Mem_Addr : request and byte address from the sequencer
//   Mem_Ack/Mem_Data : acknowledge and read byte from memory, valid together
interface byte_fetch_sequencer_if #(parameter int ADDR_W = 16);
  logic              Mem_Req;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ack;
  logic [7:0]        Mem_Data;
  modport master (output Mem_Req, Mem_Addr, input Mem_Ack, Mem_Data);
  modport slave  (input Mem_Req, Mem_Addr, output Mem_Ack, Mem_Data);
endinterface

// File: rtl/byte_fetch_sequencer_req_timeout_counter.sv
// byte_fetch_sequencer_req_timeout_counter: counts unacknowledged request cycles
//   Clock/Reset_n : clock and async active-low reset
//   clear         : hold the count at zero (outside request states)
//   enable        : one more cycle waited without Mem_Ack
//   expired       : current cycle is the last one allowed to wait
module byte_fetch_sequencer_req_timeout_counter #(
  parameter int WAIT_MAX = 15
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  // after WAIT_MAX-1 silent cycles the current one is the last; no Ack now means abort
  assign expired = cnt == CW'(WAIT_MAX - 1);
endmodule

// File: rtl/byte_fetch_sequencer.sv
// byte_fetch_sequencer: fetches one or two bytes and writes them into a FunSel register
//   Clock/Reset_n      : clock and async active-low reset
//   Start/Addr/Mode    : transaction request, first byte address, load mode
//   Busy/Done/Error    : in progress, success pulse, timeout pulse
//   mem                : memory read port (master side)
//   Reg_FunSel/E/I     : command to the target register, I = {8'h00, byte}
module byte_fetch_sequencer
  import byte_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic [ADDR_W-1:0]       Addr,
  input  logic [1:0]              Mode,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  byte_fetch_sequencer_if.master  mem,
  output logic [2:0]              Reg_FunSel,
  output logic                    Reg_E,
  output logic [15:0]             Reg_I
);
  state_t            st, nx;
  mode_t             mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        byte_q;
  logic              req, expired;
  assign req = st == REQ_LO || st == REQ_HI;
  byte_fetch_sequencer_req_timeout_counter #(.WAIT_MAX(WAIT_MAX)) u_tmo (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .clear   (!req),
    .enable  (req && !mem.Mem_Ack),
    .expired (expired)
  );
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      st     <= IDLE;
      mode_q <= MODE_WORD;
      addr_q <= '0;
      byte_q <= '0;
    end else begin
      st <= nx;
      if (st == IDLE && Start) begin
        addr_q <= Addr;
        mode_q <= mode_t'(Mode);
      end
      if (req && mem.Mem_Ack) byte_q <= mem.Mem_Data;
      // the high byte of a word sits at the next address, wrapping at the top
      if (st == WR_LO && mode_q == MODE_WORD) addr_q <= addr_q + ADDR_W'(1);
    end
  always_comb begin
    nx = st;
    case (st)
      IDLE:           if (Start) nx = mode_t'(Mode) == MODE_HIGH ? REQ_HI : REQ_LO;
      REQ_LO, REQ_HI: nx = mem.Mem_Ack ? (st == REQ_LO ? WR_LO : WR_HI) : (expired ? ERR : st);
      WR_LO:          nx = mode_q == MODE_WORD ? REQ_HI : FIN;
      WR_HI:          nx = FIN;
      default:        nx = IDLE;
    endcase
  end
  assign Busy         = st inside {REQ_LO, WR_LO, REQ_HI, WR_HI};
  assign Done         = st == FIN;
  assign Error        = st == ERR;
  assign mem.Mem_Req  = req;
  assign mem.Mem_Addr = addr_q;
  assign Reg_E        = st == WR_LO || st == WR_HI;
  assign Reg_FunSel   = st == WR_LO ? (mode_q == MODE_SEXT ? FS_SEXT : FS_LO_CLR) :
                        st == WR_HI ? FS_HI : FS_CLR;
  assign Reg_I        = {8'h00, byte_q};
endmodule

// File: tb/tb_byte_fetch_sequencer.sv
// tb_byte_fetch_sequencer: randomized and directed checks against a transaction-level model
module tb_byte_fetch_sequencer;
  import byte_fetch_sequencer_pkg::*;
  localparam int WAIT_MAX = 15;
  logic        Clock, Reset_n, Start;
  logic [15:0] Addr;
  logic [1:0]  Mode;
  logic        Busy, Done, Error, Reg_E;
  logic [2:0]  Reg_FunSel;
  logic [15:0] Reg_I;
  byte_fetch_sequencer_if #(.ADDR_W(16)) bus ();
  byte_fetch_sequencer #(.ADDR_W(16), .WAIT_MAX(WAIT_MAX)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Addr(Addr), .Mode(Mode),
    .Busy(Busy), .Done(Done), .Error(Error), .mem(bus),
    .Reg_FunSel(Reg_FunSel), .Reg_E(Reg_E), .Reg_I(Reg_I)
  );
  int          total = 0, bad = 0, ecnt = 0, t0 = 0;
  int          ack_dly = 0, acks_left = 0;
  logic        spurious = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] reg_m = 16'h0000;
  logic [26:0] wr_q[$];
  int          done_q[$], err_q[$];
  logic [15:0] req_q[$];

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end
  initial forever begin
    @(posedge Clock);
    ecnt++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin : responder
    int wcnt;
    wcnt = 0;
    bus.Mem_Ack = 0;
    bus.Mem_Data = 0;
    forever begin
      @(negedge Clock);
      if (bus.Mem_Req && acks_left > 0) begin
        if (wcnt == ack_dly) begin
          bus.Mem_Ack = 1;
          bus.Mem_Data = mem[bus.Mem_Addr];
          wcnt = 0;
          acks_left--;
        end else begin
          bus.Mem_Ack = 0;
          wcnt++;
        end
      end else begin
        bus.Mem_Ack = spurious;
        bus.Mem_Data = 8'($urandom);
        wcnt = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge Clock);
      if (Reg_E === 1'b1) begin
        wr_q.push_back({8'(ecnt - t0), Reg_FunSel, Reg_I});
        case (Reg_FunSel)
          FS_DEC:    reg_m = reg_m - 16'd1;
          FS_INC:    reg_m = reg_m + 16'd1;
          FS_LOAD:   reg_m = Reg_I;
          FS_CLR:    reg_m = 16'h0000;
          FS_LO_CLR: reg_m = {8'h00, Reg_I[7:0]};
          FS_LO:     reg_m = {reg_m[15:8], Reg_I[7:0]};
          FS_HI:     reg_m = {Reg_I[7:0], reg_m[7:0]};
          default:   reg_m = {{8{Reg_I[7]}}, Reg_I[7:0]};
        endcase
      end
      if (Done === 1'b1) done_q.push_back(ecnt - t0);
      if (Error === 1'b1) err_q.push_back(ecnt - t0);
      if (bus.Mem_Req === 1'b1) req_q.push_back(bus.Mem_Addr);
    end
  end

  task automatic start_txn(input logic [15:0] a, input logic [1:0] m);
    @(negedge Clock);
    wr_q.delete();
    done_q.delete();
    err_q.delete();
    req_q.delete();
    Start = 1;
    Addr = a;
    Mode = m;
    t0 = ecnt;
    @(negedge Clock);
    Start = 0;
    Addr = 16'($urandom);
    Mode = 2'($urandom);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && done_q.size() == 0 && err_q.size() == 0; i++) @(negedge Clock);
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_reset;
    Reset_n = 0;
    Start = 0;
    Addr = 0;
    Mode = 0;
    #12;
    total++;
    if ({Busy, Done, Error, bus.Mem_Req, Reg_E} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000", {Busy, Done, Error, bus.Mem_Req, Reg_E});
    end
    total++;
    if (Reg_FunSel !== FS_CLR) begin
      bad++;
      $display("FAIL reset_funsel: got %b want 011", Reg_FunSel);
    end
    total++;
    if (Reg_I !== 16'h0 || bus.Mem_Addr !== 16'h0) begin
      bad++;
      $display("FAIL reset_data: got I=%h addr=%h want 0000/0000", Reg_I, bus.Mem_Addr);
    end
    @(negedge Clock);
    Reset_n = 1;
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_word;
    mem[16'h0040] = 8'h34;
    mem[16'h0041] = 8'h12;
    ack_dly = 0;
    acks_left = 2;
    reg_m = 16'hA5A5;
    start_txn(16'h0040, 2'b00);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL word_busy: got %b want 1", Busy);
    end
    wait_end(40);
    total++;
    if (wr_q.size() != 2) begin
      bad++;
      $display("FAIL word_writes: got %0d writes want 2", wr_q.size());
    end else begin
      total++;
      if (wr_q[0] !== {8'd2, FS_LO_CLR, 16'h0034}) begin
        bad++;
        $display("FAIL word_wr_lo: got %h want %h", wr_q[0], {8'd2, FS_LO_CLR, 16'h0034});
      end
      total++;
      if (wr_q[1] !== {8'd4, FS_HI, 16'h0012}) begin
        bad++;
        $display("FAIL word_wr_hi: got %h want %h", wr_q[1], {8'd4, FS_HI, 16'h0012});
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != 5) begin
      bad++;
      $display("FAIL word_done: got %0d pulses first=%0d want 1 at 5", done_q.size(), done_q.size() ? done_q[0] : -1);
    end
    total++;
    if (reg_m !== 16'h1234) begin
      bad++;
      $display("FAIL word_reg: got %h want 1234", reg_m);
    end
  endtask

  task automatic test_byte_modes;
    logic [1:0]  m;
    logic [2:0]  fs;
    logic [15:0] er;
    mem[16'h0010] = 8'h85;
    for (int k = 0; k < 2; k++) begin
      m = k == 0 ? 2'b10 : 2'b01;
      fs = k == 0 ? FS_SEXT : FS_LO_CLR;
      er = k == 0 ? 16'hFF85 : 16'h0085;
      ack_dly = 0;
      acks_left = 1;
      reg_m = 16'h5A5A;
      start_txn(16'h0010, m);
      wait_end(40);
      total++;
      if (wr_q.size() != 1 || wr_q[0] !== {8'd2, fs, 16'h0085}) begin
        bad++;
        $display("FAIL byte_write mode=%b: got %0d writes first=%h want %h", m, wr_q.size(), wr_q.size() ? wr_q[0] : 27'h0, {8'd2, fs, 16'h0085});
      end
      total++;
      if (done_q.size() != 1 || done_q[0] != 3) begin
        bad++;
        $display("FAIL byte_done mode=%b: got %0d pulses first=%0d want 1 at 3", m, done_q.size(), done_q.size() ? done_q[0] : -1);
      end
      total++;
      if (reg_m !== er) begin
        bad++;
        $display("FAIL byte_reg mode=%b: got %h want %h", m, reg_m, er);
      end
    end
  endtask

  task automatic test_wait_wrap;
    int nb;
    mem[16'hFFFF] = 8'hC3;
    mem[16'h0000] = 8'h7E;
    ack_dly = 3;
    acks_left = 2;
    reg_m = 16'h0000;
    start_txn(16'hFFFF, 2'b00);
    wait_end(60);
    nb = 0;
    for (int i = 0; i < req_q.size(); i++) if (req_q[i] !== (i < 4 ? 16'hFFFF : 16'h0000)) nb++;
    total++;
    if (req_q.size() != 8 || nb != 0) begin
      bad++;
      $display("FAIL wrap_addr: got %0d req cycles %0d wrong addr want 8 cycles 0 wrong", req_q.size(), nb);
    end
    total++;
    if (wr_q.size() != 2 || wr_q[0] !== {8'd5, FS_LO_CLR, 16'h00C3} || wr_q[1] !== {8'd10, FS_HI, 16'h007E}) begin
      bad++;
      $display("FAIL wrap_writes: got %0d writes first=%h want 2 writes at cycles 5 and 10", wr_q.size(), wr_q.size() ? wr_q[0] : 27'h0);
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != 11) begin
      bad++;
      $display("FAIL wrap_done: got %0d pulses first=%0d want 1 at 11", done_q.size(), done_q.size() ? done_q[0] : -1);
    end
    total++;
    if (reg_m !== 16'h7EC3) begin
      bad++;
      $display("FAIL wrap_reg: got %h want 7ec3", reg_m);
    end
  endtask

  task automatic test_timeout;
    int nh;
    mem[16'h0200] = 8'h9A;
    ack_dly = 0;
    acks_left = 1;
    reg_m = 16'hFFFF;
    start_txn(16'h0200, 2'b00);
    wait_end(60);
    repeat (3) @(negedge Clock);
    nh = 0;
    for (int i = 0; i < req_q.size(); i++) if (req_q[i] === 16'h0201) nh++;
    total++;
    if (err_q.size() != 1 || err_q[0] != 3 + WAIT_MAX) begin
      bad++;
      $display("FAIL tmo_error: got %0d pulses first=%0d want 1 at %0d", err_q.size(), err_q.size() ? err_q[0] : -1, 3 + WAIT_MAX);
    end
    total++;
    if (done_q.size() != 0) begin
      bad++;
      $display("FAIL tmo_done: got %0d done pulses want 0", done_q.size());
    end
    total++;
    if (nh != WAIT_MAX) begin
      bad++;
      $display("FAIL tmo_wait: got %0d high-byte req cycles want %0d", nh, WAIT_MAX);
    end
    total++;
    if (wr_q.size() != 1 || reg_m !== 16'h009A) begin
      bad++;
      $display("FAIL tmo_low_kept: got %0d writes reg=%h want 1 write reg=009a", wr_q.size(), reg_m);
    end
    total++;
    if (Busy !== 1'b0 || bus.Mem_Req !== 1'b0) begin
      bad++;
      $display("FAIL tmo_idle: got busy=%b req=%b want 0/0", Busy, bus.Mem_Req);
    end
  endtask

  task automatic test_reset_mid;
    mem[16'h0300] = 8'h11;
    mem[16'h0301] = 8'h22;
    ack_dly = 0;
    acks_left = 1;
    reg_m = 16'h0000;
    start_txn(16'h0300, 2'b00);
    repeat (6) @(negedge Clock);
    #2 Reset_n = 0;
    #1;
    total++;
    if ({Busy, Done, Error, bus.Mem_Req, Reg_E} !== 5'b0 || Reg_FunSel !== FS_CLR || Reg_I !== 16'h0 || bus.Mem_Addr !== 16'h0) begin
      bad++;
      $display("FAIL midrst_outputs: got flags=%b fs=%b I=%h addr=%h want 00000/011/0000/0000", {Busy, Done, Error, bus.Mem_Req, Reg_E}, Reg_FunSel, Reg_I, bus.Mem_Addr);
    end
    repeat (2) @(negedge Clock);
    Reset_n = 1;
    repeat (3) @(negedge Clock);
    total++;
    if (done_q.size() != 0 || err_q.size() != 0 || wr_q.size() != 1) begin
      bad++;
      $display("FAIL midrst_abort: got done=%0d err=%0d writes=%0d want 0/0/1", done_q.size(), err_q.size(), wr_q.size());
    end
    acks_left = 2;
    reg_m = 16'h0000;
    start_txn(16'h0300, 2'b00);
    wait_end(40);
    total++;
    if (done_q.size() != 1 || done_q[0] != 5 || reg_m !== 16'h2211) begin
      bad++;
      $display("FAIL midrst_recover: got %0d pulses first=%0d reg=%h want 1 at 5 reg=2211", done_q.size(), done_q.size() ? done_q[0] : -1, reg_m);
    end
  endtask

  task automatic test_start_busy;
    int nb;
    mem[16'h0400] = 8'h5C;
    mem[16'h0401] = 8'hA7;
    mem[16'h0500] = 8'hFF;
    mem[16'h0501] = 8'hFF;
    ack_dly = 2;
    acks_left = 2;
    reg_m = 16'h0000;
    start_txn(16'h0400, 2'b00);
    repeat (2) @(negedge Clock);
    Start = 1;
    Addr = 16'h0500;
    Mode = 2'b01;
    @(negedge Clock);
    Start = 0;
    for (int i = 0; i < 60 && Done !== 1'b1; i++) @(negedge Clock);
    Start = 1;
    Addr = 16'h0500;
    Mode = 2'b01;
    @(negedge Clock);
    Start = 0;
    spurious = 1;
    repeat (4) @(negedge Clock);
    spurious = 0;
    repeat (2) @(negedge Clock);
    nb = 0;
    for (int i = 0; i < req_q.size(); i++) if (req_q[i] !== (i < 3 ? 16'h0400 : 16'h0401)) nb++;
    total++;
    if (done_q.size() != 1 || done_q[0] != 9) begin
      bad++;
      $display("FAIL busy_done: got %0d pulses first=%0d want 1 at 9", done_q.size(), done_q.size() ? done_q[0] : -1);
    end
    total++;
    if (req_q.size() != 6 || nb != 0) begin
      bad++;
      $display("FAIL busy_reqs: got %0d req cycles %0d wrong addr want 6 cycles 0 wrong", req_q.size(), nb);
    end
    total++;
    if (wr_q.size() != 2 || reg_m !== 16'hA75C) begin
      bad++;
      $display("FAIL busy_reg: got %0d writes reg=%h want 2 writes reg=a75c", wr_q.size(), reg_m);
    end
    total++;
    if (Busy !== 1'b0 || bus.Mem_Req !== 1'b0) begin
      bad++;
      $display("FAIL busy_idle: got busy=%b req=%b want 0/0", Busy, bus.Mem_Req);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, a1, r0, er;
    logic [1:0]  m;
    logic [7:0]  lo, hi;
    logic [26:0] e0, e1;
    int          d, n, ed, nb;
    for (int it = 0; it < 24; it++) begin
      a = 16'($urandom);
      a1 = a + 16'd1;
      m = 2'($urandom);
      d = int'($urandom_range(0, 4));
      lo = 8'($urandom);
      hi = 8'($urandom);
      r0 = 16'($urandom);
      mem[a] = lo;
      mem[a1] = hi;
      reg_m = r0;
      ack_dly = d;
      acks_left = 2;
      n = m == 2'b00 ? 2 : 1;
      e0 = {8'(2 + d), m == 2'b10 ? FS_SEXT : m == 2'b11 ? FS_HI : FS_LO_CLR, 8'h00, lo};
      e1 = {8'(4 + 2 * d), FS_HI, 8'h00, hi};
      er = m == 2'b00 ? {hi, lo} : m == 2'b01 ? {8'h00, lo} : m == 2'b10 ? {{8{lo[7]}}, lo} : {lo, r0[7:0]};
      ed = m == 2'b00 ? 5 + 2 * d : 3 + d;
      start_txn(a, m);
      wait_end(60);
      nb = 0;
      for (int i = 0; i < req_q.size(); i++) if (req_q[i] !== (i <= d ? a : a1)) nb++;
      total++;
      if (wr_q.size() != n || wr_q[0] !== e0 || (n == 2 && wr_q[1] !== e1)) begin
        bad++;
        $display("FAIL rand_writes it=%0d mode=%b: got %0d writes first=%h want %0d first=%h", it, m, wr_q.size(), wr_q.size() ? wr_q[0] : 27'h0, n, e0);
      end
      total++;
      if (done_q.size() != 1 || done_q[0] != ed) begin
        bad++;
        $display("FAIL rand_done it=%0d mode=%b: got %0d pulses first=%0d want 1 at %0d", it, m, done_q.size(), done_q.size() ? done_q[0] : -1, ed);
      end
      total++;
      if (reg_m !== er) begin
        bad++;
        $display("FAIL rand_reg it=%0d mode=%b: got %h want %h", it, m, reg_m, er);
      end
      total++;
      if (req_q.size() != n * (d + 1) || nb != 0) begin
        bad++;
        $display("FAIL rand_reqs it=%0d mode=%b: got %0d cycles %0d wrong want %0d cycles", it, m, req_q.size(), nb, n * (d + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_modes();
    test_wait_wrap();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/byte_fetch_sequencer.md
Name: byte_fetch_sequencer

Overview:
- Writer-side sequencer for the 16-bit FunSel register: fetches one or two bytes from the 8-bit memory port and issues the matching FunSel/E/I commands to load them into a target register.
- Sits between the control unit and any FunSel-controlled register, e.g. IR or an address register.
- The control unit issues one Start; the block runs the memory handshake, byte assembly, extension mode and timeout on its own.

Parameters:
- ADDR_W, 16, memory address width.
- WAIT_MAX, 15, maximum cycles Mem_Req may wait for Mem_Ack before aborting; must be ≥1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request; ignored while Busy=1.
- Addr  in  ADDR_W  byte address of the first byte; latched on Start.
- Mode  in  2  00 word (low byte at Addr, high byte at Addr+1); 01 byte, zero-extend; 10 byte, sign-extend; 11 byte into upper half only.
- Busy  out  1  high from the cycle after Start until Done or Error is asserted.
- Done  out  1  one-cycle pulse on successful completion.
- Error  out  1  one-cycle pulse on timeout.
- Mem_Req  out  1  memory read request.
- Mem_Addr  out  ADDR_W  read address; stable while Mem_Req=1.
- Mem_Ack  in  1  memory acknowledge; Mem_Data is valid in the same cycle.
- Mem_Data  in  8  read byte.
- Reg_FunSel  out  3  FunSel driven to the target register.
- Reg_E  out  1  register enable; one-cycle pulse per write.
- Reg_I  out  16  register data, always {8'h00, byte}.

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE.
  - Busy, Done, Error, Mem_Req, Reg_E = 0.
  - Reg_FunSel=3'b011, Reg_I=0, Mem_Addr=0, timeout counter=0.
  - Applies immediately, including mid-transaction. A transaction aborted by reset produces no Done or Error and no further register write.
- All outputs are registered (Moore), decoded from the state and the captured byte.
- States: IDLE, REQ_LO, WR_LO, REQ_HI, WR_HI, FIN, ERR.
- IDLE:
  - Start=1 → latch Addr and Mode; go to REQ_LO.
  - Mode=11 → go to REQ_HI instead, with address = Addr.
- REQ_LO / REQ_HI:
  - Mem_Req=1, Mem_Addr = the latched address (REQ_HI in word mode: Addr+1 mod 2^ADDR_W, so FFFF wraps to 0000).
  - Mem_Ack=1 at a rising edge → capture Mem_Data, go to WR_LO or WR_HI respectively.
  - Otherwise the counter increments; reaching WAIT_MAX with no Ack → ERR.
  - Counter clears on every state entry.
- WR_LO:
  - Reg_E=1, Reg_I={00, byte}.
  - Reg_FunSel: Mode 00 → 100; 01 → 100; 10 → 111.
  - Next state: REQ_HI for Mode 00, else FIN.
- WR_HI:
  - Reg_E=1, Reg_FunSel=110, Reg_I={00, byte}.
  - Next state: FIN.
- FIN: Done=1 for one cycle, then IDLE.
- ERR: Error=1 for one cycle, then IDLE. A low byte already written stays in the register; no rollback.
- Mem_Req deasserts in the cycle after Ack, because the state has changed. Consecutive Acks are never assumed.
- Reg_E=0 in every state except WR_LO and WR_HI.
- Zero-wait memory (Ack on the first Req cycle), Start sampled at edge 0:
  - Word mode: Req cycle 1, WR_LO cycle 2, Req cycle 3, WR_HI cycle 4, Done cycle 5.
  - Byte modes: Done in cycle 3.
- Start in the same cycle as Done/Error (state FIN/ERR): ignored; the control unit must re-issue it in IDLE.
- Mem_Ack while not requesting: ignored.

Decomposition:
- Shared package:
  - Mode encodings: MODE_WORD, MODE_ZEXT, MODE_SEXT, MODE_HIGH.
  - FunSel constants: FS_DEC=000, FS_INC=001, FS_LOAD=010, FS_CLR=011, FS_LO_CLR=100, FS_LO=101, FS_HI=110, FS_SEXT=111.
  - State encoding.
- Optional sub-module: req_timeout_counter (clear, enable, WAIT_MAX, expired flag). Everything else stays in a single FSM module.

Test Plan:
- Word, zero-wait memory: Addr=0x0040, mem[0x40]=0x34, mem[0x41]=0x12, Mode=00.
  - Reg_E pulses with FunSel=100, I=0x0034 in cycle 2, then FunSel=110, I=0x0012 in cycle 4; Done in cycle 5.
  - The attached Register ends at 0x1234.
- Sign-extend: mem[0x10]=0x85, Mode=10 → one write with FunSel=111, I=0x0085; register=0xFF85; Done in cycle 3. Same test with Mode=01 → FunSel=100, register=0x0085.
- Wait states and wrap: Addr=0xFFFF, Ack delayed 3 cycles per byte.
  - Mem_Addr is held at 0xFFFF, then at 0x0000, for the full wait.
  - Done in cycle 11.
- Timeout: WAIT_MAX=15, high byte never acknowledged → Error pulses once; low byte already written; Done never asserted; Busy=0 afterwards.
- Reset mid-WR_HI wait, then recovery: Reset_n low → all outputs 0 and Reg_FunSel=011 immediately; a new Start afterwards completes normally.
- Start while Busy plus a spurious Ack in IDLE → both ignored; exactly one Done per accepted Start.
